rf_writeback: RTL and testbench

- Write-side controller for the 32x32 RISC-V register file; owns the single write port (we/WriteN/In) for the pipeline.
- Merges single-cycle ALU results with long-latency results from the load/store unit (LSU), which are buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding long-latency destinations and raises a decode-stage stall on RAW/WAW hazards against them.

---
 rtl/rf_writeback.sv | 129 ++++++++++++
 tb/tb_rf_writeback.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Write-side controller for the 32x32 register file: merges ALU results with
// FIFO-buffered LSU results onto the single write port and tracks busy registers.
module rf_writeback #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [4:0]              lsu_rd,
  input  logic [XLEN-1:0]         lsu_data,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rd,
  input  logic [4:0]              dec_rs1,
  input  logic [4:0]              dec_rs2,
  input  logic [4:0]              dec_rd,
  output logic                    stall,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [31:0]             busy,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_we;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [31:0]     r_busy;

  logic            w_full;
  logic            w_alu_wr;
  logic            w_push;
  logic            w_pop;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;
  logic [31:0]     w_busy_next;

  assign w_full      = (r_count == FULL);
  assign w_alu_wr    = alu_valid & (alu_rd != 5'd0);
  // Beats for x0 are accepted (handshake completes) but never stored.
  assign w_push      = lsu_valid & ~w_full & (lsu_rd != 5'd0);
  assign w_pop       = ~w_alu_wr & (r_count != '0);
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // NOTE: storage array has no reset; validity comes from the pointers/count, and
  // leaving it unreset lets it map to plain flops or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= lsu_rd;
      r_fifo_data[r_wptr] <= lsu_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Idle cycles keep the last address/data so the port does not toggle needlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_alu_wr | w_pop;
      if (w_alu_wr) begin
        r_waddr <= alu_rd;
        r_wdata <= alu_data;
      end else if (w_pop) begin
        r_waddr <= w_head_rd;
        r_wdata <= w_head_data;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid && (iss_rd != 5'd0)) w_set[iss_rd] = 1'b1;
    if (w_pop) w_clr[w_head_rd] = 1'b1;
    // A new issue to the retiring register keeps it busy.
    w_busy_next    = (r_busy & ~w_clr) | w_set;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_next;
  end

  assign stall     = r_busy[dec_rs1] | r_busy[dec_rs2] | r_busy[dec_rd];
  assign lsu_ready = ~w_full;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign busy      = r_busy;
  assign q_count   = r_count;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: expected writes are queued as stimulus is
// driven and matched against the register-file port as writes appear.
module tb_rf_writeback;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   alu_valid;
  logic [4:0]             alu_rd;
  logic [XLEN-1:0]        alu_data;
  logic                   lsu_valid;
  logic                   lsu_ready;
  logic [4:0]             lsu_rd;
  logic [XLEN-1:0]        lsu_data;
  logic                   iss_valid;
  logic [4:0]             iss_rd;
  logic [4:0]             dec_rs1;
  logic [4:0]             dec_rs2;
  logic [4:0]             dec_rd;
  logic                   stall;
  logic                   rf_we;
  logic [4:0]             rf_waddr;
  logic [XLEN-1:0]        rf_wdata;
  logic [31:0]            busy;
  logic [$clog2(DEPTH):0] q_count;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t lsu_exp[$];
  int  n_vec = 0;
  int  n_err = 0;

  rf_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .dec_rs1   (dec_rs1),
    .dec_rs2   (dec_rs2),
    .dec_rd    (dec_rd),
    .stall     (stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .q_count   (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic            alu_pend;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            acc;
    wr_t             beat;
    wr_t             got;
    alu_pend = rst_n && alu_valid && (alu_rd != 5'd0);
    a_rd     = alu_rd;
    a_data   = alu_data;
    acc      = rst_n && lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    beat     = '{rd: lsu_rd, data: lsu_data};
    if (alu_pend) check("alu_rd_not_busy", 64'(busy[a_rd]), 64'd0);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (alu_pend) begin
        check("alu_we",    64'(rf_we),    64'd1);
        check("alu_waddr", 64'(rf_waddr), 64'(a_rd));
        check("alu_wdata", 64'(rf_wdata), 64'(a_data));
      end else if (rf_we) begin
        if (lsu_exp.size() == 0) begin
          check("spurious_we", 64'(rf_we), 64'd0);
        end else begin
          got = lsu_exp.pop_front();
          check("lsu_waddr", 64'(rf_waddr), 64'(got.rd));
          check("lsu_wdata", 64'(rf_wdata), 64'(got.data));
        end
      end
      if (acc) lsu_exp.push_back(beat);
    end
  endtask

  initial begin
    int   b;
    int   acc_n;
    int   cyc;
    logic acc;

    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_rd    = '0;

    // Power-on reset.
    repeat (2) tick();
    check("rst_we",    64'(rf_we),     64'd0);
    check("rst_waddr", 64'(rf_waddr),  64'd0);
    check("rst_wdata", 64'(rf_wdata),  64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_qcnt",  64'(q_count),   64'd0);
    check("rst_ready", 64'(lsu_ready), 64'd1);
    check("rst_stall", 64'(stall),     64'd0);
    rst_n = 1'b1;
    tick();

    // ALU-only stream.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    check("alu_c1_we",    64'(rf_we),    64'd1);
    check("alu_c1_waddr", 64'(rf_waddr), 64'd5);
    check("alu_c1_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    alu_rd = 5'd0; alu_data = 32'h1111_1111;
    tick();
    check("alu_x0_we",    64'(rf_we),    64'd0);
    check("hold_waddr",   64'(rf_waddr), 64'd5);
    check("hold_wdata",   64'(rf_wdata), 64'hDEAD_BEEF);
    alu_rd = 5'd31; alu_data = 32'hAAAA_5555;
    tick();
    alu_rd = 5'd1;  alu_data = 32'h0;
    tick();
    alu_valid = 1'b0;
    tick();
    check("alu_idle_we", 64'(rf_we), 64'd0);

    // Long-latency flow on x7.
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    check("iss7_busy", 64'(busy), 64'h80);
    dec_rs1 = 5'd7; #1;
    check("stall_rs1", 64'(stall), 64'd1);
    dec_rs1 = 5'd0; dec_rs2 = 5'd7; #1;
    check("stall_rs2", 64'(stall), 64'd1);
    dec_rs2 = 5'd0; dec_rd = 5'd7; #1;
    check("stall_rd", 64'(stall), 64'd1);
    dec_rd = 5'd6; #1;
    check("no_stall_6", 64'(stall), 64'd0);
    dec_rd = 5'd0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
    tick();
    lsu_valid = 1'b0;
    check("lsu_c1_we",   64'(rf_we),   64'd0);
    check("lsu_c1_qcnt", 64'(q_count), 64'd1);
    check("lsu_c1_busy", 64'(busy),    64'h80);
    dec_rs1 = 5'd7;
    tick();
    check("lsu_c2_we",    64'(rf_we),    64'd1);
    check("lsu_c2_waddr", 64'(rf_waddr), 64'd7);
    check("lsu_c2_wdata", 64'(rf_wdata), 64'h1234);
    check("lsu_c2_busy",  64'(busy),     64'd0);
    check("lsu_c2_stall", 64'(stall),    64'd0);
    dec_rs1 = 5'd0;

    // ALU priority starves the FIFO until it fills.
    b = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + c % 3); alu_data = 32'hA000_0000 + 32'(c);
      lsu_valid = (b < 5); lsu_rd = 5'(10 + b); lsu_data = 32'h100 + 32'(b);
      acc = lsu_valid && lsu_ready;
      tick();
      if (acc) b++;
    end
    check("bp_accepted", 64'(b),         64'd4);
    check("bp_qcnt",     64'(q_count),   64'd4);
    check("bp_ready",    64'(lsu_ready), 64'd0);
    alu_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      lsu_valid = (b < 5); lsu_rd = 5'(10 + b); lsu_data = 32'h100 + 32'(b);
      acc = lsu_valid && lsu_ready;
      tick();
      if (acc) b++;
      if (k == 0) begin
        check("ready_after_pop", 64'(lsu_ready), 64'd1);
        check("qcnt_after_pop",  64'(q_count),   64'd3);
      end
      check("drain_we", 64'(rf_we), (k < 5) ? 64'd1 : 64'd0);
    end
    lsu_valid = 1'b0;
    check("drain_qcnt", 64'(q_count), 64'd0);

    // Pop of x9 coincides with a new issue of x9.
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999;
    tick();
    lsu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    check("setclr_we",   64'(rf_we),    64'd1);
    check("setclr_busy", 64'(busy),     64'h200);
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9A9A;
    tick();
    lsu_valid = 1'b0;
    tick();
    check("x9_release", 64'(busy), 64'd0);

    // Push and pop together at occupancy 2.
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h2020;
    tick();
    lsu_rd = 5'd21; lsu_data = 32'h2121;
    tick();
    check("pp_pre_qcnt", 64'(q_count), 64'd2);
    alu_valid = 1'b0;
    lsu_rd = 5'd22; lsu_data = 32'h2222_2222;
    tick();
    lsu_valid = 1'b0;
    check("pp_qcnt", 64'(q_count), 64'd2);
    repeat (2) tick();
    check("pp_drain", 64'(q_count), 64'd0);

    // Pointer wrap: 40 accepted beats with random ALU contention.
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 10 * DEPTH && cyc < 400) begin
      alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'd3; alu_data = $urandom;
      lsu_valid = ($urandom_range(0, 3) != 0); lsu_rd = 5'(1 + acc_n % 31); lsu_data = $urandom;
      acc = lsu_valid && lsu_ready;
      tick();
      if (acc) acc_n++;
      cyc++;
    end
    check("wrap_beats", 64'(acc_n), 64'(10 * DEPTH));
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    repeat (DEPTH + 2) tick();
    check("wrap_qcnt",     64'(q_count),        64'd0);
    check("wrap_sb_empty", 64'(lsu_exp.size()), 64'd0);

    // Zero register is never busy, stored or written.
    iss_valid = 1'b1; iss_rd = 5'd0;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBAD0;
    dec_rs1 = 5'd0;
    tick();
    iss_valid = 1'b0;
    lsu_valid = 1'b0;
    check("x0_busy",  64'(busy),    64'd0);
    check("x0_qcnt",  64'(q_count), 64'd0);
    check("x0_stall", 64'(stall),   64'd0);
    tick();
    check("x0_we", 64'(rf_we), 64'd0);

    // Reset mid-stream: 3 queued entries, x4..x6 busy, ALU writing.
    for (int r = 4; r <= 6; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
      tick();
    end
    iss_valid = 1'b0;
    for (int r = 4; r <= 6; r++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hC000_0000 + 32'(r);
      lsu_valid = 1'b1; lsu_rd = 5'(r); lsu_data = 32'h4000 + 32'(r);
      tick();
    end
    check("pre_rst_qcnt", 64'(q_count), 64'd3);
    check("pre_rst_busy", 64'(busy),    64'h70);
    check("pre_rst_we",   64'(rf_we),   64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we",    64'(rf_we),     64'd0);
    check("mid_rst_busy",  64'(busy),      64'd0);
    check("mid_rst_qcnt",  64'(q_count),   64'd0);
    check("mid_rst_ready", 64'(lsu_ready), 64'd1);
    lsu_exp.delete();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_we",   64'(rf_we),   64'd0);
    check("post_rst_qcnt", 64'(q_count), 64'd0);
    check("end_sb_empty",  64'(lsu_exp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
